// File: rtl/tc_scheduler_pkg.sv
// tc_pkg: shared types, constants and helpers for the 4x4 transform-chain scheduler.
package tc_pkg;

   localparam int MB_BLOCKS = 16;
   localparam int QP_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } tc_state_e;

   typedef logic [3:0]      blk_idx_t;
   typedef logic [QP_W-1:0] qp_t;
   typedef logic [4:0]      blk_cnt_t;   // 0..16: one code past the last block index

   localparam blk_idx_t LAST_BLK_IDX = 4'd15;
   localparam blk_cnt_t LAST_BLK_CNT = 5'd15;
   localparam blk_cnt_t FULL_CNT     = blk_cnt_t'(MB_BLOCKS);

   // Accept counter increment that sticks at a full macroblock.
   function automatic blk_cnt_t cnt_inc_sat(input blk_cnt_t cnt);
      blk_cnt_t nxt;
      if (cnt >= FULL_CNT) begin
         nxt = FULL_CNT;
      end else begin
         nxt = cnt + 5'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/tc_scheduler_if.sv
// tc_scheduler_if: handshake, configuration and status bundle between the
// residual generator / transform datapath side (master) and the scheduler (slave).
interface tc_scheduler_if #(
   parameter int STAGES = 4
);
   import tc_pkg::*;

   logic              enable;
   logic              mb_start;
   qp_t               qp_by_6_in;
   qp_t               qp_mod_6_in;
   logic              in_valid;
   logic              in_ready;
   blk_idx_t          in_blk_idx;
   logic [STAGES-1:0] stage_en;
   qp_t               qp_by_6;
   qp_t               qp_mod_6;
   logic              out_valid;
   logic              out_ready;
   blk_idx_t          out_blk_idx;
   logic              busy;
   logic              mb_done;

   modport slave (
      input  enable, mb_start, qp_by_6_in, qp_mod_6_in, in_valid, out_ready,
      output in_ready, in_blk_idx, stage_en, qp_by_6, qp_mod_6,
             out_valid, out_blk_idx, busy, mb_done
   );

   modport master (
      output enable, mb_start, qp_by_6_in, qp_mod_6_in, in_valid, out_ready,
      input  in_ready, in_blk_idx, stage_en, qp_by_6, qp_mod_6,
             out_valid, out_blk_idx, busy, mb_done
   );

endinterface

// File: rtl/tc_scheduler_valid_pipe.sv
// tc_valid_pipe: STAGES-deep valid + block-index shadow of the datapath stages.
// The whole pipe moves one stage when 'advance' is high and holds otherwise.
module tc_valid_pipe
   import tc_pkg::*;
#(
   parameter int STAGES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              advance,
   input  logic              in_vld,
   input  blk_idx_t          in_idx,
   output logic [STAGES-1:0] vld,
   output blk_idx_t          out_idx
);

   logic [STAGES-1:0]      vld_d, vld_q;
   logic [STAGES-1:0][3:0] idx_d, idx_q;

   // Next contents: shift one stage on advance, otherwise hold; empty slots carry index 0.
   always_comb begin
      vld_d = vld_q;
      idx_d = idx_q;
      if (advance) begin
         vld_d[0] = in_vld;
         idx_d[0] = in_vld ? in_idx : 4'd0;
         for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            idx_d[k] = idx_q[k-1];
         end
      end else begin
         vld_d = vld_q;
         idx_d = idx_q;
      end
   end

   // Stage registers with synchronous reset discarding everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= {STAGES{1'b0}};
         idx_q <= {STAGES{4'd0}};
      end else begin
         vld_q <= vld_d;
         idx_q <= idx_d;
      end
   end

   assign vld     = vld_q;
   assign out_idx = idx_q[STAGES-1];

endmodule

// File: rtl/tc_scheduler.sv
// tc_scheduler: sequences one macroblock of 16 4x4 residual blocks through the
// fixed-latency transform chain, generating stage enables and back-pressure stalls,
// holding the macroblock QP and pulsing mb_done when the last block leaves.
module tc_scheduler
   import tc_pkg::*;
#(
   parameter int STAGES = 4
) (
   input logic           clk,
   input logic           reset,
   tc_scheduler_if.slave bus
);

   tc_state_e         state_d, state_q;
   blk_cnt_t          cnt_d, cnt_q;
   qp_t               qp_by_6_d, qp_by_6_q;
   qp_t               qp_mod_6_d, qp_mod_6_q;
   logic              mb_done_d, mb_done_q;

   logic [STAGES-1:0] vld_s;
   blk_idx_t          out_idx_s;
   logic              advance_s;
   logic              in_ready_s;
   logic              accept_s;
   logic              out_hs_s;
   logic [STAGES-1:0] stage_en_s;

   tc_valid_pipe #(
      .STAGES (STAGES)
   ) u_valid_pipe (
      .clk     (clk),
      .reset   (reset),
      .advance (advance_s),
      .in_vld  (accept_s),
      .in_idx  (cnt_q[3:0]),
      .vld     (vld_s),
      .out_idx (out_idx_s)
   );

   // Chain advance, input accept, output handshake and per-stage load enables.
   always_comb begin
      advance_s  = bus.enable && (!vld_s[STAGES-1] || bus.out_ready);
      in_ready_s = advance_s && (state_q == RUN);
      accept_s   = bus.in_valid && in_ready_s;
      out_hs_s   = advance_s && vld_s[STAGES-1];
      stage_en_s = {STAGES{1'b0}};
      stage_en_s[0] = accept_s;
      for (int k = 1; k < STAGES; k++) begin
         stage_en_s[k] = advance_s && vld_s[k-1];
      end
   end

   // Macroblock FSM next state, accept counter, QP latch and completion pulse.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      qp_by_6_d  = qp_by_6_q;
      qp_mod_6_d = qp_mod_6_q;
      mb_done_d  = 1'b0;
      if (bus.enable) begin
         case (state_q)
            IDLE: begin
               if (bus.mb_start) begin
                  state_d    = RUN;
                  cnt_d      = 5'd0;
                  qp_by_6_d  = bus.qp_by_6_in;
                  qp_mod_6_d = bus.qp_mod_6_in;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (accept_s) begin
                  cnt_d = cnt_inc_sat(cnt_q);
                  if (cnt_q == LAST_BLK_CNT) begin
                     state_d = DRAIN;
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  state_d = RUN;
               end
            end
            DRAIN: begin
               if (out_hs_s && (out_idx_s == LAST_BLK_IDX)) begin
                  state_d   = DONE;
                  mb_done_d = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end
            DONE: begin
               // A start arriving together with DONE is dropped on purpose.
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Control registers; enable low holds everything except the one-shot done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 5'd0;
         qp_by_6_q  <= {QP_W{1'b0}};
         qp_mod_6_q <= {QP_W{1'b0}};
         mb_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         qp_by_6_q  <= qp_by_6_d;
         qp_mod_6_q <= qp_mod_6_d;
         mb_done_q  <= mb_done_d;
      end
   end

   assign bus.in_ready    = in_ready_s;
   assign bus.in_blk_idx  = cnt_q[3:0];
   assign bus.stage_en    = stage_en_s;
   assign bus.qp_by_6     = qp_by_6_q;
   assign bus.qp_mod_6    = qp_mod_6_q;
   assign bus.out_valid   = vld_s[STAGES-1];
   assign bus.out_blk_idx = out_idx_s;
   assign bus.busy        = (state_q != IDLE);
   assign bus.mb_done     = mb_done_q;

endmodule

// File: tb/tb_tc_scheduler.sv
// tb_tc_scheduler: directed scenarios for tc_scheduler. Each cycle the observable
// outputs are packed as {in_ready, in_blk_idx, stage_en, out_valid, out_blk_idx,
// mb_done, busy, qp_by_6, qp_mod_6} and compared against a hand-derived schedule.
module tb_tc_scheduler;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   tc_scheduler_if #(.STAGES(4)) bus ();

   tc_scheduler #(.STAGES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Block index accepted at effective cycle t of a run whose input stream pauses
   // for gap_len cycles starting at gap_at; -1 when nothing is accepted.
   function automatic int blk_at(input int t, input int gap_at, input int gap_len);
      int b;
      if (t < 0) b = -1;
      else if (t < gap_at) b = t;
      else if (t < gap_at + gap_len) b = -1;
      else b = t - gap_len;
      if (b > 15) b = -1;
      return b;
   endfunction

   // Expected packed outputs at effective cycle t (t=0 is the first RUN cycle).
   // frz marks a stalled/disabled cycle: state as at t, but no accept and no stage loads.
   function automatic logic [23:0] exp_vec(input int t, input int gap_at, input int gap_len,
                                           input logic [3:0] qb, input logic [3:0] qm,
                                           input logic frz);
      int         last;
      int         ob;
      logic       rdy;
      logic [3:0] iidx;
      logic [3:0] en;
      logic       ov;
      logic [3:0] oidx;
      last = 15 + gap_len;
      rdy  = (t <= last) && !frz;
      if (t > last) iidx = 4'd0;
      else if (t < gap_at) iidx = 4'(t);
      else if (t < gap_at + gap_len) iidx = 4'(gap_at);
      else iidx = 4'(t - gap_len);
      for (int k = 0; k < 4; k++) en[k] = !frz && (blk_at(t - k, gap_at, gap_len) >= 0);
      ob   = blk_at(t - 4, gap_at, gap_len);
      ov   = (ob >= 0);
      oidx = ov ? 4'(ob) : 4'd0;
      return {rdy, iidx, en, ov, oidx, (t == last + 5), (t <= last + 5), qb, qm};
   endfunction

   // Packed view of the DUT outputs; indices are shown only where they are defined.
   function automatic logic [23:0] sample(input logic idx_known);
      return {bus.in_ready, idx_known ? bus.in_blk_idx : 4'd0, bus.stage_en, bus.out_valid,
              bus.out_valid ? bus.out_blk_idx : 4'd0, bus.mb_done, bus.busy,
              bus.qp_by_6, bus.qp_mod_6};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic start_mb(input logic [3:0] qb, input logic [3:0] qm);
      bus.mb_start    = 1'b1;
      bus.qp_by_6_in  = qb;
      bus.qp_mod_6_in = qm;
      bus.in_valid    = 1'b1;
      next_cycle();
      bus.mb_start    = 1'b0;
      bus.qp_by_6_in  = ~qb;
      bus.qp_mod_6_in = ~qm;
   endtask

   task automatic test_reset();
      logic [23:0] o;
      repeat (2) @(posedge clk);
      @(negedge clk);
      o = sample(1'b1);
      n_checks++;
      if (o !== 24'h0) $display("FAIL reset_held got %h exp %h", o, 24'h0); else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         o = sample(1'b1);
         n_checks++;
         if (o !== 24'h0) $display("FAIL reset_idle c=%0d got %h exp %h", c, o, 24'h0); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_full_mb(input logic [3:0] qb, input logic [3:0] qm);
      logic [23:0] o;
      logic [23:0] e;
      start_mb(qb, qm);
      for (int c = 0; c < 23; c++) begin
         @(negedge clk);
         e = exp_vec(c, 99, 0, qb, qm, 1'b0);
         o = sample(c <= 15);
         n_checks++;
         if (o !== e) $display("FAIL full_mb c=%0d got %h exp %h", c, o, e); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_stall();
      logic [23:0] o;
      logic [23:0] e;
      int          t;
      logic        frz;
      start_mb(4'd3, 4'd4);
      for (int c = 0; c < 25; c++) begin
         frz = (c >= 6) && (c <= 8);
         bus.out_ready = !frz;
         @(negedge clk);
         t = (c < 6) ? c : (frz ? 6 : c - 3);
         e = exp_vec(t, 99, 0, 4'd3, 4'd4, frz);
         o = sample(t <= 15);
         n_checks++;
         if (o !== e) $display("FAIL stall c=%0d got %h exp %h", c, o, e); else n_pass++;
         next_cycle();
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_gaps();
      logic [23:0] o;
      logic [23:0] e;
      start_mb(4'd8, 4'd5);
      for (int c = 0; c < 24; c++) begin
         bus.in_valid = !((c == 4) || (c == 5));
         @(negedge clk);
         e = exp_vec(c, 4, 2, 4'd8, 4'd5, 1'b0);
         o = sample(c <= 17);
         n_checks++;
         if (o !== e) $display("FAIL gaps c=%0d got %h exp %h", c, o, e); else n_pass++;
         next_cycle();
      end
      bus.in_valid = 1'b1;
   endtask

   task automatic test_mb_start_ignored();
      logic [23:0] o;
      logic [23:0] e;
      start_mb(4'd5, 4'd2);
      for (int c = 0; c < 23; c++) begin
         bus.mb_start    = (c == 2) || (c == 20);
         bus.qp_by_6_in  = 4'd9;
         bus.qp_mod_6_in = 4'd1;
         @(negedge clk);
         e = exp_vec(c, 99, 0, 4'd5, 4'd2, 1'b0);
         o = sample(c <= 15);
         n_checks++;
         if (o !== e) $display("FAIL start_ignored c=%0d got %h exp %h", c, o, e); else n_pass++;
         next_cycle();
      end
      bus.mb_start = 1'b0;
   endtask

   task automatic test_enable_freeze();
      logic [23:0] o;
      logic [23:0] e;
      int          t;
      logic        frz;
      start_mb(4'd2, 4'd3);
      for (int c = 0; c < 27; c++) begin
         frz = (c >= 5) && (c <= 9);
         bus.enable = !frz;
         @(negedge clk);
         t = (c < 5) ? c : (frz ? 5 : c - 5);
         e = exp_vec(t, 99, 0, 4'd2, 4'd3, frz);
         o = sample(t <= 15);
         n_checks++;
         if (o !== e) $display("FAIL enable_freeze c=%0d got %h exp %h", c, o, e); else n_pass++;
         next_cycle();
      end
      bus.enable = 1'b1;
   endtask

   task automatic test_reset_in_drain();
      logic [23:0] o;
      logic [23:0] e;
      start_mb(4'd6, 4'd1);
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         e = exp_vec(c, 99, 0, 4'd6, 4'd1, 1'b0);
         o = sample(c <= 15);
         n_checks++;
         if (o !== e) $display("FAIL drain_pre c=%0d got %h exp %h", c, o, e); else n_pass++;
         if (c == 17) reset = 1'b1;
         next_cycle();
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         o = sample(1'b1);
         n_checks++;
         if (o !== 24'h0) $display("FAIL drain_reset c=%0d got %h exp %h", c, o, 24'h0); else n_pass++;
         next_cycle();
      end
      test_full_mb(4'd7, 4'd3);
   endtask

   initial begin
      n_checks        = 0;
      n_pass          = 0;
      clk             = 1'b0;
      reset           = 1'b1;
      bus.enable      = 1'b1;
      bus.mb_start    = 1'b0;
      bus.qp_by_6_in  = 4'd0;
      bus.qp_mod_6_in = 4'd0;
      bus.in_valid    = 1'b1;
      bus.out_ready   = 1'b1;
      test_reset();
      test_full_mb(4'd5, 4'd2);
      test_stall();
      test_gaps();
      test_mb_start_ignored();
      test_enable_freeze();
      test_reset_in_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
